// File: rtl/power3_arbiter.sv
// power3_arbiter
// Round-robin arbiter that shares one fixed-latency, non-stallable cube unit
// among N_REQ requesters. The block issues at most one operand per cycle. A
// tag pipeline follows each operand through the unit. Results are captured
// into a response FIFO. Issue is credit-limited, so a result that leaves the
// unit always has a FIFO slot waiting for it.
//
// Ports:
//   i_clk, i_arst             clock (rising edge), async active-high reset
//   i_reqValid / i_reqData    per-requester request valid and packed operands
//   o_reqReady                one-hot grant (combinational)
//   o_unitX / o_unitValid     registered operand to the cube unit
//   i_unitXPower              cube unit result, LATENCY cycles after o_unitX
//   o_rspValid/o_rspId/o_rspData, i_rspReady   response FIFO head, valid/ready
//   o_busy                    operations in flight or responses buffered
module power3_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic [N_REQ-1:0]           i_reqValid,
    input  logic [N_REQ*WIDTH-1:0]     i_reqData,
    output logic [N_REQ-1:0]           o_reqReady,
    output logic [WIDTH-1:0]           o_unitX,
    output logic                       o_unitValid,
    input  logic [WIDTH-1:0]           i_unitXPower,
    output logic                       o_rspValid,
    output logic [$clog2(N_REQ)-1:0]   o_rspId,
    output logic [WIDTH-1:0]           o_rspData,
    input  logic                       i_rspReady,
    output logic                       o_busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_credit;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [WIDTH-1:0] r_unitX;
    logic             r_tagV  [LATENCY+1];
    logic [IDW-1:0]   r_tagId [LATENCY+1];
    logic [IDW-1:0]   r_memId   [FIFO_DEPTH];
    logic [WIDTH-1:0] r_memData [FIFO_DEPTH];

    logic [WIDTH-1:0] w_reqX [N_REQ];
    logic             w_grantValid;
    logic [IDW-1:0]   w_grantId;
    logic [IDW-1:0]   w_cand;
    logic             w_push;
    logic             w_pop;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_reqX[k] = i_reqData[k*WIDTH +: WIDTH];
    end

    // Search from the pointer with wrap. Grants are suppressed while reset is
    // asserted, so every output reads 0 during reset.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = '0;
        w_cand       = r_ptr;
        o_reqReady   = '0;
        if (!i_arst && (r_credit < DEPTH_C)) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_grantValid && i_reqValid[w_cand]) begin
                    w_grantValid = 1'b1;
                    w_grantId    = w_cand;
                end
                w_cand = (w_cand == IDW'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
            end
        end
        if (w_grantValid) begin
            o_reqReady[w_grantId] = 1'b1;
        end
    end

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stage 0 is registered together with o_unitX. Stage LATENCY therefore
    // lines up with the unit result for that operand.
    assign w_push = r_tagV[LATENCY];
    assign w_pop  = (r_count != '0) && i_rspReady;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_ptr    <= '0;
            r_credit <= '0;
            r_count  <= '0;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_unitX  <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                r_tagV[s]  <= 1'b0;
                r_tagId[s] <= '0;
            end
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                r_memId[e]   <= '0;
                r_memData[e] <= '0;
            end
        end else begin
            r_tagV[0]  <= w_grantValid;
            r_tagId[0] <= w_grantId;
            r_unitX    <= w_grantValid ? w_reqX[w_grantId] : '0;
            for (int s = 1; s <= LATENCY; s++) begin
                r_tagV[s]  <= r_tagV[s-1];
                r_tagId[s] <= r_tagId[s-1];
            end
            if (w_grantValid) begin
                r_ptr <= (w_grantId == IDW'(N_REQ - 1)) ? '0 : w_grantId + 1'b1;
            end

            if (w_push) begin
                r_memId[r_wrPtr]   <= r_tagId[LATENCY];
                r_memData[r_wrPtr] <= i_unitXPower;
                r_wrPtr            <= f_inc(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= f_inc(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A credit is held from issue until the response is popped. A tag
            // moving from the pipeline into the FIFO does not change the total.
            case ({w_grantValid, w_pop})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign o_unitX     = r_unitX;
    assign o_unitValid = r_tagV[0];
    assign o_rspValid  = (r_count != '0);
    assign o_rspId     = o_rspValid ? r_memId[r_rdPtr] : '0;
    assign o_rspData   = o_rspValid ? r_memData[r_rdPtr] : '0;
    assign o_busy      = (r_credit != '0);

endmodule

// File: tb/tb_power3_arbiter.sv
module tb_power3_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 3;
    localparam int D = 4;

    logic           clk;
    logic           i_arst;
    logic [N-1:0]   i_reqValid;
    logic [N*W-1:0] i_reqData;
    logic [N-1:0]   o_reqReady;
    logic [W-1:0]   o_unitX;
    logic           o_unitValid;
    logic [W-1:0]   i_unitXPower;
    logic           o_rspValid;
    logic [1:0]     o_rspId;
    logic [W-1:0]   o_rspData;
    logic           i_rspReady;
    logic           o_busy;

    power3_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_arst(i_arst), .i_reqValid(i_reqValid), .i_reqData(i_reqData),
        .o_reqReady(o_reqReady), .o_unitX(o_unitX), .o_unitValid(o_unitValid),
        .i_unitXPower(i_unitXPower), .o_rspValid(o_rspValid), .o_rspId(o_rspId),
        .o_rspData(o_rspData), .i_rspReady(i_rspReady), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] cube(input logic [W-1:0] x);
        logic [3*W-1:0] a;
        logic [3*W-1:0] p;
        a = (3*W)'(x);
        p = a * a * a;
        return p[W-1:0];
    endfunction

    // Stand-in for the external cube unit: fixed latency L, no stall.
    logic [W-1:0] unit_pipe [L];
    initial for (int k = 0; k < L; k++) unit_pipe[k] = '0;
    always @(posedge clk) begin
        unit_pipe[0] <= o_unitX;
        for (int k = 1; k < L; k++) unit_pipe[k] <= unit_pipe[k-1];
    end
    assign i_unitXPower = cube(unit_pipe[L-1]);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each issued operation is an entry in a queue. It is
    // either in flight until its due cycle or waiting in the response queue.
    typedef struct { int id; int data; int due; } op_t;
    typedef struct { int id; int data; int cyc; } rsp_t;
    op_t  infl[$];
    rsp_t mfifo[$];
    rsp_t pops[$];
    int   mptr = 0;
    int   mcyc = 0;
    int   exp_uv = 0;
    int   exp_ux = 0;
    logic [N-1:0] last_ready;

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        infl.delete();
        mfifo.delete();
        mptr   = 0;
        exp_uv = 0;
        exp_ux = 0;
    endfunction

    // One cycle. It is entered and left on a negedge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy);
        int g;
        int cred;
        logic [W-1:0] x;
        i_reqValid = v;
        i_reqData  = d;
        i_rspReady = rdy;
        #1;
        cred = infl.size() + mfifo.size();
        g = -1;
        if (cred < D) begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (mptr + i) % N;
                if (g < 0 && v[j]) g = j;
            end
        end
        chk("reqReady", o_reqReady, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("unitValid", o_unitValid, exp_uv);
        chk("unitX", o_unitX, exp_ux);
        chk("rspValid", o_rspValid, mfifo.size() > 0);
        if (mfifo.size() > 0) begin
            chk("rspId", o_rspId, mfifo[0].id);
            chk("rspData", o_rspData, mfifo[0].data);
        end
        chk("busy", o_busy, cred != 0);
        last_ready = o_reqReady;
        @(posedge clk);
        if (mfifo.size() > 0 && rdy) begin
            pops.push_back('{mfifo[0].id, mfifo[0].data, mcyc});
            void'(mfifo.pop_front());
        end
        if (infl.size() > 0 && infl[0].due == mcyc) begin
            mfifo.push_back('{infl[0].id, infl[0].data, mcyc});
            void'(infl.pop_front());
        end
        if (g >= 0) begin
            x = d[g*W +: W];
            infl.push_back('{g, int'(cube(x)), mcyc + 1 + L});
            exp_uv = 1;
            exp_ux = int'(x);
            mptr   = (g + 1) % N;
        end else begin
            exp_uv = 0;
            exp_ux = 0;
        end
        mcyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_arst = 1'b1;
        #1;
        chk("rst_reqReady", o_reqReady, 0);
        chk("rst_unitValid", o_unitValid, 0);
        chk("rst_unitX", o_unitX, 0);
        chk("rst_rspValid", o_rspValid, 0);
        chk("rst_rspId", o_rspId, 0);
        chk("rst_rspData", o_rspData, 0);
        chk("rst_busy", o_busy, 0);
        model_reset();
        repeat (2) @(negedge clk);
        i_arst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((infl.size() + mfifo.size()) > 0 && n < 40) begin
            step('0, '0, 1'b1);
            n++;
        end
        chk("drain_done", o_busy, 0);
    endtask

    initial begin
        int cnt;
        int gseq[$];
        int pop_step;
        int grant_step;
        int k;
        i_arst     = 1'b1;
        i_reqValid = '0;
        i_reqData  = '0;
        i_rspReady = 1'b0;
        @(negedge clk);
        do_reset();

        // Single request from requester 2, x=3
        step(4'b0100, {8'd0, 8'd3, 8'd0, 8'd0}, 1'b1);
        chk("t1_grant", last_ready, 4'b0100);
        repeat (4) step('0, '0, 1'b1);
        chk("t1_rspValid", o_rspValid, 1);
        chk("t1_rspId", o_rspId, 2);
        chk("t1_rspData", o_rspData, 27);
        step('0, '0, 1'b1);
        chk("t1_busy_low", o_busy, 0);

        // Value sweep via requester 0
        pops.delete();
        step(4'b0001, 32'd7, 1'b1);
        step(4'b0001, 32'd16, 1'b1);
        step(4'b0001, 32'd255, 1'b1);
        step(4'b0001, 32'd5, 1'b1);
        drain();
        chk("t2_npops", pops.size(), 4);
        if (pops.size() == 4) begin
            chk("t2_d0", pops[0].data, 87);
            chk("t2_d1", pops[1].data, 0);
            chk("t2_d2", pops[2].data, 255);
            chk("t2_d3", pops[3].data, 125);
            for (int i = 1; i < 4; i++) chk("t2_consec", pops[i].cyc, pops[0].cyc + i);
        end

        // All requesters valid continuously: fair rotation
        do_reset();
        pops.delete();
        k = 0;
        while (gseq.size() < 8 && k < 60) begin
            step(4'b1111, 32'($urandom), 1'b1);
            if (last_ready != 0) gseq.push_back(onehot_idx(last_ready));
            k++;
        end
        chk("t3_ngrants", gseq.size(), 8);
        for (int i = 0; i < gseq.size(); i++) chk("t3_order", gseq[i], i % 4);
        drain();
        chk("t3_npops", pops.size(), 8);
        for (int i = 0; i < pops.size(); i++) chk("t3_rsp_order", pops[i].id, i % 4);

        // Backpressure: credits run out after FIFO_DEPTH grants
        do_reset();
        pops.delete();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 32'($urandom), 1'b0);
            if (last_ready != 0) cnt++;
        end
        chk("t4_grants", cnt, 4);
        chk("t4_stalled", last_ready, 0);
        chk("t4_full_valid", o_rspValid, 1);
        pop_step = -1;
        grant_step = -1;
        k = 0;
        while (grant_step < 0 && k < 20) begin
            step(4'b1111, 32'($urandom), 1'b1);
            if (last_ready != 0) grant_step = k;
            if (pop_step < 0 && pops.size() > 0) pop_step = k;
            k++;
        end
        chk("t4_regrant_after_pop", grant_step, pop_step + 1);
        drain();
        chk("t4_npops", pops.size(), 5);
        for (int i = 0; i < 4 && i < pops.size(); i++) chk("t4_drain_order", pops[i].id, i);

        // Pointer at 2, requesters 1 and 3 valid
        do_reset();
        step(4'b0010, 32'($urandom), 1'b1);
        drain();
        step(4'b1010, 32'($urandom), 1'b1);
        chk("t5_g0", last_ready, 4'b1000);
        step(4'b1010, 32'($urandom), 1'b1);
        chk("t5_g1", last_ready, 4'b0010);
        step(4'b1010, 32'($urandom), 1'b1);
        chk("t5_g2", last_ready, 4'b1000);
        drain();

        // Reset with three operations in flight
        do_reset();
        repeat (3) step(4'b1111, 32'($urandom), 1'b1);
        chk("t6_inflight", o_busy, 1);
        i_reqValid = 4'b1111;
        do_reset();
        pops.delete();
        step(4'b1111, 32'($urandom), 1'b1);
        chk("t6_first_grant", last_ready, 4'b0001);
        repeat (10) step('0, '0, 1'b1);
        chk("t6_npops", pops.size(), 1);
        if (pops.size() > 0) chk("t6_pop_id", pops[0].id, 0);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(4'($urandom), 32'($urandom), ($urandom_range(0, 9) < 7));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
